// File: rtl/memctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memctl_pkg
// Purpose  : Shared types and width constants for the unified-RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package memctl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // Arbiter control state, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IBUSY = 3'd1,
    DBUSY = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } arb_state_t;

  // Grant decision produced by the priority block
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  // Streak counter width: enough for 0..max_streak, never narrower than 1 bit
  function automatic int streak_width(input int max_streak);
    return (max_streak > 0) ? $clog2(max_streak + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_priority.sv
`default_nettype none
// ============================================================================
// Module   : arb_priority
// Purpose  : Data-first grant decision with a starvation guard that forces an
//            instruction grant after MAX_DSTREAK data grants made while an
//            instruction fetch was waiting.
// Revision : 1.0 - initial release
// ============================================================================
module arb_priority
  import memctl_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_iren,
  input  logic   i_dreq,
  input  logic   i_grant_en,
  output grant_t o_grant
);

  localparam int              SW    = streak_width(MAX_DSTREAK);
  localparam logic [SW-1:0]   C_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] r_dstreak;
  logic          w_guard;
  grant_t        w_grant;

  // Data wins unless the fetch side has waited through a full streak
  always_comb begin
    w_guard = i_iren && (MAX_DSTREAK != 0) && (r_dstreak == C_MAX);
    w_grant = GNT_NONE;
    if (i_dreq && !w_guard) begin
      w_grant = GNT_D;
    end else if (i_iren) begin
      w_grant = GNT_I;
    end
  end

  assign o_grant = w_grant;

  // Count data grants that bypassed a waiting fetch; any other grant clears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dstreak <= '0;
    end else if (i_grant_en && (w_grant != GNT_NONE)) begin
      if ((w_grant == GNT_D) && i_iren) begin
        if (r_dstreak != C_MAX) begin
          r_dstreak <= r_dstreak + 1'b1;
        end
      end else begin
        r_dstreak <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported RAM between instruction fetch and the
//            data stage. One access at a time, registered RAM-side signals
//            held until ramready, one-cycle hit pulse with the read data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import memctl_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready
);

  arb_state_t        r_state;
  logic              r_ram_ren;
  logic              r_ram_wen;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_store;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              r_ihit;
  logic              r_dhit;

  logic              w_dreq;
  logic              w_grant_en;
  grant_t            w_grant;

  assign w_dreq     = dREN | dWEN;
  // Grants are only ever made from IDLE, so a request still high during a
  // response cycle cannot be served a second time.
  assign w_grant_en = (r_state == IDLE);

  arb_priority #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_arb_priority (
    .clk        (CLK),
    .rst        (RST),
    .i_iren     (iREN),
    .i_dreq     (w_dreq),
    .i_grant_en (w_grant_en),
    .o_grant    (w_grant)
  );

  // Access sequencing: latch on grant, hold through BUSY, pulse hit in RESP
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_store <= '0;
      r_iload     <= '0;
      r_dload     <= '0;
      r_ihit      <= 1'b0;
      r_dhit      <= 1'b0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          case (w_grant)
            GNT_I: begin
              r_state    <= IBUSY;
              r_ram_ren  <= 1'b1;
              r_ram_wen  <= 1'b0;
              r_ram_addr <= iaddr;
            end
            GNT_D: begin
              // A simultaneous read and write request is served as a write
              r_state     <= DBUSY;
              r_ram_ren   <= ~dWEN;
              r_ram_wen   <= dWEN;
              r_ram_addr  <= daddr;
              r_ram_store <= dstore;
            end
            default: begin
            end
          endcase
        end
        IBUSY: begin
          if (ramready) begin
            r_iload   <= ramload;
            r_ram_ren <= 1'b0;
            r_ihit    <= 1'b1;
            r_state   <= IRESP;
          end
        end
        DBUSY: begin
          if (ramready) begin
            if (!r_ram_wen) begin
              r_dload <= ramload;
            end
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            r_dhit    <= 1'b1;
            r_state   <= DRESP;
          end
        end
        IRESP, DRESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ramREN   = r_ram_ren;
  assign ramWEN   = r_ram_wen;
  assign ramaddr  = r_ram_addr;
  assign ramstore = r_ram_store;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ihit     = r_ihit;
  assign dhit     = r_dhit;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter; the bench plays both
//            requesters and the RAM, and predicts grants, strobes and loads
//            from a transaction-level model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] iload;
  logic          ihit;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic [DW-1:0] dload;
  logic          dhit;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ramready;

  mem_arbiter #(
    .MAX_DSTREAK (MAXS),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .ihit     (ihit),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dhit     (dhit),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramready (ramready)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: consecutive data grants past a waiting fetch, and the
  // last value each side should have received.
  int          m_streak = 0;
  logic [DW-1:0] m_iload = '0;
  logic [DW-1:0] m_dload = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string t);
    chk({t, "_ramREN"}, ramREN, 1'b0);
    chk({t, "_ramWEN"}, ramWEN, 1'b0);
    chk({t, "_ihit"}, ihit, 1'b0);
    chk({t, "_dhit"}, dhit, 1'b0);
    chk({t, "_iload"}, iload, m_iload);
    chk({t, "_dload"}, dload, m_dload);
  endtask

  // One arbitration round, entered and left at a falling edge with the DUT idle
  task automatic episode(input bit new_i, input bit new_drd, input bit new_dwr,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] ds, input int delay,
                         input logic [DW-1:0] rload, input bit do_rst,
                         input bit drop_mid, input bit spur, output byte gnt);
    byte           g;
    bit            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_store;
    idle_check("idle");
    if (new_i && !iREN) begin
      iREN  = 1'b1;
      iaddr = ia;
    end
    if ((new_drd || new_dwr) && !(dREN || dWEN)) begin
      dREN   = new_drd;
      dWEN   = new_dwr;
      daddr  = da;
      dstore = ds;
    end
    gnt = "-";
    if (!iREN && !(dREN || dWEN)) begin
      ramready = spur;
      @(negedge CLK);
      ramready = 1'b0;
      return;
    end
    if ((dREN || dWEN) && !(iREN && (MAXS != 0) && (m_streak == MAXS))) g = "D";
    else g = "I";
    exp_wr    = (g == "D") && dWEN;
    exp_addr  = (g == "D") ? daddr : iaddr;
    exp_store = dstore;
    if ((g == "D") && iREN) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    else m_streak = 0;
    gnt = g;
    @(negedge CLK);
    chk("grant_ramREN", ramREN, !exp_wr);
    chk("grant_ramWEN", ramWEN, exp_wr);
    chk("grant_ramaddr", ramaddr, exp_addr);
    if (g == "D") chk("grant_ramstore", ramstore, exp_store);
    for (int k = 0; k < delay; k++) begin
      if (g == "D") begin
        daddr  = $urandom;
        dstore = $urandom;
        if (drop_mid) begin
          dREN = 1'b0;
          dWEN = 1'b0;
        end
      end else begin
        iaddr = $urandom;
        if (drop_mid) iREN = 1'b0;
      end
      if (do_rst) begin
        RST  = 1'b1;
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        @(negedge CLK);
        chk("rst_ramREN", ramREN, 1'b0);
        chk("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_ihit", ihit, 1'b0);
        chk("rst_dhit", dhit, 1'b0);
        RST      = 1'b0;
        m_streak = 0;
        m_iload  = '0;
        m_dload  = '0;
        return;
      end
      @(negedge CLK);
      chk("busy_ramREN", ramREN, !exp_wr);
      chk("busy_ramWEN", ramWEN, exp_wr);
      chk("busy_ramaddr", ramaddr, exp_addr);
      if (g == "D") chk("busy_ramstore", ramstore, exp_store);
      chk("busy_hits", {ihit, dhit}, 2'b00);
    end
    ramready = 1'b1;
    ramload  = rload;
    @(negedge CLK);
    ramready = spur;
    ramload  = $urandom;
    if (g == "I") m_iload = rload;
    else if (!exp_wr) m_dload = rload;
    chk("resp_ihit", ihit, g == "I");
    chk("resp_dhit", dhit, g == "D");
    chk("resp_iload", iload, m_iload);
    chk("resp_dload", dload, m_dload);
    chk("resp_strobes", {ramREN, ramWEN}, 2'b00);
    @(negedge CLK);
    ramready = 1'b0;
    if (g == "I") iREN = 1'b0;
    else begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  initial begin
    byte   g;
    string ord;
    bit    b_i, b_r, b_w, b_rst, b_drop, b_spur;
    RST = 1'b1;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ramready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_iload", iload, 32'h0);
    chk("reset_dload", dload, 32'h0);
    chk("reset_hits", {ihit, dhit}, 2'b00);
    chk("reset_strobes", {ramREN, ramWEN}, 2'b00);
    chk("reset_ramaddr", ramaddr, 32'h0);
    chk("reset_ramstore", ramstore, 32'h0);
    RST = 1'b0;

    // Single fetch, RAM answers in the first strobe cycle
    episode(1, 0, 0, 32'h40, '0, '0, 0, 32'h2408_0005, 0, 0, 0, g);
    chk("fetch_grant", g, "I");

    // Simultaneous fetch and data read: data first, then the fetch
    episode(1, 1, 0, 32'h80, 32'h100, '0, 1, 32'hDEAD_BEEF, 0, 0, 0, g);
    chk("both_first", g, "D");
    episode(0, 0, 0, '0, '0, '0, 0, 32'h1111_2222, 0, 0, 0, g);
    chk("both_second", g, "I");

    // Writes kept coming while a fetch waits: guard forces every third grant
    ord = "DDIDDI";
    for (int n = 0; n < 6; n++) begin
      episode(1, 0, 1, 32'h1000 + n, 32'h300 + n, 32'hA000 + n, n % 3, $urandom, 0, 0, 0, g);
      chk("streak_order", g, ord[n]);
    end
    episode(0, 0, 0, '0, '0, '0, 0, $urandom, 0, 0, 0, g);

    // Slow write: signals held for five cycles, dload untouched
    episode(0, 0, 1, '0, 32'h200, 32'h1234_5678, 5, 32'hFFFF_0000, 0, 0, 0, g);
    chk("slow_write", g, "D");

    // Reset during a data access, then a normal fetch
    episode(0, 1, 0, '0, 32'h400, '0, 3, $urandom, 1, 0, 0, g);
    episode(1, 0, 0, 32'h44, '0, '0, 1, 32'h0BAD_F00D, 0, 0, 0, g);
    chk("post_rst_fetch", g, "I");

    // Data request dropped mid-access, spurious ready in RESP and in IDLE
    episode(0, 1, 0, '0, 32'h500, '0, 2, 32'h5555_AAAA, 0, 1, 1, g);
    episode(0, 0, 0, '0, '0, '0, 0, '0, 0, 0, 1, g);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      b_i    = ($urandom_range(0, 1) == 1);
      b_r    = ($urandom_range(0, 1) == 1);
      b_w    = ($urandom_range(0, 3) == 0);
      b_rst  = ($urandom_range(0, 19) == 0);
      b_drop = ($urandom_range(0, 4) == 0);
      b_spur = ($urandom_range(0, 1) == 1);
      episode(b_i, b_r, b_w, $urandom, $urandom, $urandom, $urandom_range(0, 4),
              $urandom, b_rst, b_drop, b_spur, g);
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (8) @(negedge CLK);
    idle_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
